// File: rtl/posit_pkg.sv
// posit_pkg: shared posit constants, decoded-operand record and width helpers
package posit_pkg;
    function automatic int scale_w(int n, int es);
        return $clog2(n) + es + 2;
    endfunction
    localparam int SCW = scale_w(32, 4) + 2;
    localparam int FRW = 32;
    typedef struct packed {
        logic sign;
        logic zero;
        logic nar;
        logic signed [SCW-1:0] scale;
        logic [FRW-1:0] frac;
    } posit_dec_t;
    function automatic logic [31:0] nar(int n);
        return 32'd1 << (n - 1);
    endfunction
    function automatic logic [31:0] maxpos(int n);
        return (32'd1 << (n - 1)) - 32'd1;
    endfunction
    function automatic logic [31:0] minpos(int n);
        return {31'd0, n > 0};
    endfunction
endpackage

// File: rtl/posit_decode.sv
// posit_decode: splits a posit into sign, special flags, combined scale and hidden-one mantissa
module posit_decode
    import posit_pkg::*;
#(
    parameter int N = 16,
    parameter int ES = 3
) (
    input  logic [N-1:0] p,
    output posit_dec_t   d
);
    localparam int FW = N - ES - 2;
    logic [N-2:0] body, rem;
    logic run;
    int m, k;
    always_comb begin
        body = (N-1)'(p[N-1] ? -p : p);
        run = 1'b1;
        m = 0;
        for (int i = N - 2; i >= 0; i--) begin
            run = run && body[i] == body[N-2];
            m = m + int'(run);
        end
        k = body[N-2] ? m - 1 : -m;
        rem = body << (m + 1);
        d.sign = p[N-1];
        d.zero = p == '0;
        d.nar = p == N'(nar(N));
        d.scale = SCW'(k * (2 ** ES) + int'(rem >> (N - 1 - ES)));
        d.frac = FRW'({1'b1, (FW-1)'((rem << ES) >> (ES + 2))});
    end
endmodule

// File: rtl/posit_mul_pipe.sv
// posit_mul_pipe: pipelined posit multiplier (decode/multiply/round), flags port with POSIT_MUL_FLAGS_EN
module posit_mul_pipe
    import posit_pkg::*;
#(
    parameter int N = 16,
    parameter int ES = 3,
    parameter int PIPE_OUT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] posit
`ifdef POSIT_MUL_FLAGS_EN
    ,
    output logic [3:0]   flags
`endif
);
    localparam int FW = N - ES - 2;
    localparam int FRB = 2 * FW - 1;
    localparam int T = ES + FRB;
    localparam int BW = N + T;
    posit_dec_t dx, dy, s1_dx, s1_dy;
    logic adv, s1_v, s2_v, s3_v, s4_v, s2_sign, s2_zero, s2_nar;
    logic signed [SCW-1:0] s2_scale;
    logic [2*FW-1:0] s2_prod;
    logic [FRB-1:0] fr;
    logic [BW-1:0] rg, big;
    logic [N-2:0] body;
    logic guard, sticky, ones, up, ovr, und;
    logic [N-1:0] mag, res, s3_p, s4_p;
    int sc, k3, e3, len;
`ifdef POSIT_MUL_FLAGS_EN
    logic sat;
    logic [3:0] fl, s3_f, s4_f;
`endif

    assign adv = !out_valid || out_ready;
    assign in_ready = adv;

    posit_decode #(.N(N), .ES(ES)) u_dx (.p(x), .d(dx));
    posit_decode #(.N(N), .ES(ES)) u_dy (.p(y), .d(dy));

    always_comb begin
        fr = s2_prod[2*FW-1] ? s2_prod[2*FW-2:0] : {s2_prod[2*FW-3:0], 1'b0};
        sc = int'(s2_scale) + int'(s2_prod[2*FW-1]);
        k3 = sc >>> ES;
        e3 = sc & ((1 << ES) - 1);
        len = k3 >= 0 ? k3 + 2 : 1 - k3;
        rg = k3 >= 0 ? ((BW'(1) << (k3 + 1)) - BW'(1)) << 1 : BW'(1);
        big = ((rg << T) | (BW'(e3) << FRB) | BW'(fr)) << (N - len);
        body = big[BW-1 -: N-1];
        guard = big[BW-N];
        sticky = |big[BW-N-1:0];
        ones = &body;
        up = guard && (sticky || body[0]) && !ones;
        ovr = k3 > N - 2;
        und = k3 < 2 - N;
        mag = ovr ? N'(maxpos(N)) : und ? N'(minpos(N)) : {1'b0, body + (N-1)'(up)};
        res = s2_nar ? N'(nar(N)) : s2_zero ? '0 : s2_sign ? -mag : mag;
    end

`ifdef POSIT_MUL_FLAGS_EN
    always_comb begin
        sat = !s2_nar && !s2_zero && (ovr || und || (ones && (guard || sticky)));
        fl = {s2_nar, s2_zero && !s2_nar, sat, sat || (!s2_nar && !s2_zero && (guard || sticky))};
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
            s3_v <= 1'b0;
            s4_v <= 1'b0;
            s3_p <= '0;
            s4_p <= '0;
`ifdef POSIT_MUL_FLAGS_EN
            s3_f <= '0;
            s4_f <= '0;
`endif
        end else if (adv) begin
            s1_v <= in_valid;
            s1_dx <= dx;
            s1_dy <= dy;
            s2_v <= s1_v;
            s2_sign <= s1_dx.sign ^ s1_dy.sign;
            s2_zero <= s1_dx.zero || s1_dy.zero;
            s2_nar <= s1_dx.nar || s1_dy.nar;
            s2_scale <= s1_dx.scale + s1_dy.scale;
            s2_prod <= (2*FW)'({32'd0, s1_dx.frac} * {32'd0, s1_dy.frac});
            s3_v <= s2_v;
            s3_p <= res;
            s4_v <= s3_v;
            s4_p <= s3_p;
`ifdef POSIT_MUL_FLAGS_EN
            s3_f <= fl;
            s4_f <= s3_f;
`endif
        end
    end

`ifdef POSIT_MUL_FLAGS_EN
    assign {out_valid, posit, flags} = PIPE_OUT != 0 ? {s4_v, s4_p, s4_f} : {s3_v, s3_p, s3_f};
`else
    assign {out_valid, posit} = PIPE_OUT != 0 ? {s4_v, s4_p} : {s3_v, s3_p};
`endif
endmodule

// File: tb/tb_posit_mul_pipe.sv
// tb_posit_mul_pipe: directed vectors and handshake/reset sequences for posit_mul_pipe (N=16, ES=3, PIPE_OUT=0)
module tb_posit_mul_pipe;
    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] p;
        logic [3:0]  f;
    } vec_t;

    logic clk = 1'b0;
    logic rst, in_valid, in_ready, out_valid, out_ready;
    logic [15:0] x, y, posit, held;
`ifdef POSIT_MUL_FLAGS_EN
    logic [3:0] flags;
`endif
    int pass = 0;
    int total = 0;
    vec_t v [15];

    posit_mul_pipe #(.N(16), .ES(3), .PIPE_OUT(0)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .x(x),
        .y(y),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .posit(posit)
`ifdef POSIT_MUL_FLAGS_EN
        ,
        .flags(flags)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic run_vec(input vec_t t, input int i);
        int lat;
        @(negedge clk);
        x = t.x;
        y = t.y;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 99;
        for (int n = 1; n <= 10 && lat == 99; n++) begin
            @(negedge clk);
            if (out_valid) lat = n;
        end
        chk($sformatf("latency[%0d]", i), lat, 3);
        chk($sformatf("posit[%0d]", i), posit, t.p);
`ifdef POSIT_MUL_FLAGS_EN
        chk($sformatf("flags[%0d]", i), flags, t.f);
`endif
    endtask

    initial begin
        int sent, got, leaks;
        v[0]  = '{16'h0000, 16'h6AD5, 16'h0000, 4'b0100};
        v[1]  = '{16'h8000, 16'h0000, 16'h8000, 4'b1000};
        v[2]  = '{16'h8000, 16'hAD15, 16'h8000, 4'b1000};
        v[3]  = '{16'h4000, 16'hAD15, 16'hAD15, 4'b0000};
        v[4]  = '{16'hC000, 16'hAD15, 16'h52EB, 4'b0000};
        v[5]  = '{16'h4200, 16'h4200, 16'h4480, 4'b0000};
        v[6]  = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 4'b0011};
        v[7]  = '{16'h0001, 16'h0001, 16'h0001, 4'b0011};
        v[8]  = '{16'h4200, 16'h4001, 16'h4202, 4'b0001};
        v[9]  = '{16'h4001, 16'h4001, 16'h4002, 4'b0001};
        v[10] = '{16'h4200, 16'h4003, 16'h4204, 4'b0001};
        v[11] = '{16'hC000, 16'hC000, 16'h4000, 4'b0000};
        v[12] = '{16'hBE00, 16'h4200, 16'hBB80, 4'b0000};
        v[13] = '{16'h0000, 16'h8000, 16'h8000, 4'b1000};
        v[14] = '{16'h4400, 16'h4400, 16'h4800, 4'b0000};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        x = '0;
        y = '0;
        repeat (2) @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_posit", posit, 0);
`ifdef POSIT_MUL_FLAGS_EN
        chk("reset_flags", flags, 0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 15; i++) run_vec(v[i], i);

        sent = 0;
        got = 0;
        held = '0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            @(negedge clk);
            out_ready = !(c == 6 || c == 7);
            in_valid = sent < 8;
            if (sent < 8) begin
                x = v[sent].x;
                y = v[sent].y;
            end
            #1;
            if (c == 6) held = posit;
            if (c == 7 || c == 8) begin
                chk($sformatf("stall_hold[%0d]", c), posit, held);
                chk($sformatf("stall_valid[%0d]", c), out_valid, 1);
            end
            if (c == 6 || c == 7) chk($sformatf("stall_in_ready[%0d]", c), in_ready, 0);
            if (out_valid && out_ready) begin
                chk($sformatf("stream[%0d]", got), posit, v[got].p);
                got++;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("stream_count", got, 8);
        leaks = 0;
        repeat (6) begin
            @(negedge clk);
            leaks += int'(out_valid);
        end
        chk("stream_no_dup", leaks, 0);

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            x = v[3+i].x;
            y = v[3+i].y;
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        rst = 1'b1;
        #1 chk("flush_pre_valid", out_valid, 1);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        chk("flush_posit", posit, 0);
        leaks = 0;
        repeat (8) begin
            @(negedge clk);
            leaks += int'(out_valid);
        end
        chk("flush_no_leak", leaks, 0);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
